// File: rtl/qtz_im_seq.sv
// qtz_im_seq: quantized item-memory sequencer for the sparse HDC encoder.
// Define QTZ_PRUNE_EN to honour feat_keep and skip pruned features.
module qtz_im_seq #(
  parameter int N_FEATURES = 617,
  parameter int M          = 16,
  parameter int FEAT_W     = 8,
  parameter int SEG_COUNT  = 2,
  localparam int LVL_W = $clog2(M),
  localparam int FI_W  = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1,
  localparam int SEG_W = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass_done,
  output logic              feat_rd_en,
  output logic [FI_W-1:0]   feat_addr,
  input  logic [FEAT_W-1:0] feat_data,
  input  logic              feat_keep,
  output logic [SEG_W-1:0]  mapping_hv_segment,
  output logic              item_valid,
  input  logic              item_ready,
  output logic [FI_W-1:0]   item_feat,
  output logic [LVL_W-1:0]  item_level
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [FI_W-1:0]  FI_LAST = FI_W'(N_FEATURES - 1);
  localparam logic [SEG_W-1:0] SI_LAST = SEG_W'(SEG_COUNT - 1);

  state_t           state, state_n;
  logic [FI_W-1:0]  fi, fi_n;
  logic [SEG_W-1:0] si, si_n;
  logic [FI_W-1:0]  feat_q, feat_n;
  logic [LVL_W-1:0] lvl_q, lvl_n;
  logic             advance;
  logic             pass_end;
  logic             pass_q;
  logic             done_q;
  logic             keep;
  logic             unused_in;

`ifdef QTZ_PRUNE_EN
  assign keep      = feat_keep;
  assign unused_in = ^feat_data;
`else
  assign keep      = 1'b1;
  assign unused_in = ^{feat_keep, feat_data};
`endif

  always_comb begin
    state_n  = state;
    fi_n     = fi;
    si_n     = si;
    feat_n   = feat_q;
    lvl_n    = lvl_q;
    advance  = 1'b0;
    pass_end = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          fi_n    = '0;
          si_n    = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: state_n = S_WAIT;
      S_WAIT: begin
        // level is the top LVL_W bits of the feature
        lvl_n  = feat_data[FEAT_W-1 -: LVL_W];
        feat_n = fi;
        if (keep) state_n = S_EMIT;
        else      advance = 1'b1;
      end
      S_EMIT: advance = item_ready;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (advance) begin
      if (fi != FI_LAST) begin
        fi_n    = fi + 1'b1;
        state_n = S_FETCH;
      end else begin
        pass_end = 1'b1;
        fi_n     = '0;
        if (si != SI_LAST) begin
          si_n    = si + 1'b1;
          state_n = S_FETCH;
        end else begin
          state_n = S_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      fi     <= '0;
      si     <= '0;
      feat_q <= '0;
      lvl_q  <= '0;
      pass_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      fi     <= fi_n;
      si     <= si_n;
      feat_q <= feat_n;
      lvl_q  <= lvl_n;
      pass_q <= pass_end;
      done_q <= (state == S_DONE);
    end
  end

  assign busy               = (state != S_IDLE);
  assign feat_rd_en         = (state == S_FETCH);
  assign feat_addr          = fi;
  assign item_valid         = (state == S_EMIT);
  assign item_feat          = feat_q;
  assign item_level         = lvl_q;
  assign mapping_hv_segment = si;
  assign pass_done          = pass_q;
  assign done               = done_q;

endmodule

// File: tb/tb_qtz_im_seq.sv
// tb_qtz_im_seq: randomized bench for qtz_im_seq with a queue-based item model.
// Compile with the same QTZ_PRUNE_EN setting as the design.
module tb_qtz_im_seq;

  localparam int NF = 4;
  localparam int NS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, pass_done, feat_rd_en;
  logic [1:0] feat_addr;
  logic [7:0] feat_data = '0;
  logic       feat_keep = 1'b0;
  logic [0:0] mapping_hv_segment;
  logic       item_valid;
  logic       item_ready;
  logic [1:0] item_feat;
  logic [3:0] item_level;

  qtz_im_seq #(
    .N_FEATURES(NF),
    .M(16),
    .FEAT_W(8),
    .SEG_COUNT(NS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .done(done),
    .pass_done(pass_done),
    .feat_rd_en(feat_rd_en),
    .feat_addr(feat_addr),
    .feat_data(feat_data),
    .feat_keep(feat_keep),
    .mapping_hv_segment(mapping_hv_segment),
    .item_valid(item_valid),
    .item_ready(item_ready),
    .item_feat(item_feat),
    .item_level(item_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int seg;
    int feat;
    int lvl;
  } item_t;

  logic [7:0] mem [NF];
  logic       kmask [NF];
  item_t      exp_q [$];
  item_t      obs_q [$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pd_cnt, done_cnt, n_items, n_exp, done_cyc, t0;
  logic prev_pd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // feature buffer: one-cycle read latency
  always @(posedge clk) begin
    if (feat_rd_en) begin
      feat_data <= mem[feat_addr];
      feat_keep <= kmask[feat_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit kept(input int f);
`ifdef QTZ_PRUNE_EN
    return kmask[f];
`else
    return 1'b1;
`endif
  endfunction

  function automatic void build_model();
    item_t it;
    exp_q.delete();
    n_exp = 0;
    for (int s = 0; s < NS; s++)
      for (int f = 0; f < NF; f++)
        if (kept(f)) begin
          it.seg  = s;
          it.feat = f;
          it.lvl  = int'(mem[f]) / 16;
          exp_q.push_back(it);
          n_exp++;
        end
  endfunction

  // start-to-done distance with item_ready held high
  function automatic int ideal_off();
    int c = 2;
    for (int s = 0; s < NS; s++)
      for (int f = 0; f < NF; f++)
        c += kept(f) ? 3 : 2;
    return c;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (item_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_item: got feat %0d seg %0d, none expected",
                   item_feat, mapping_hv_segment);
        end else begin
          chk("item_feat", item_feat, exp_q[0].feat);
          chk("item_level", item_level, exp_q[0].lvl);
          chk("item_seg", mapping_hv_segment, exp_q[0].seg);
          if (item_ready) begin
            obs_q.push_back(exp_q[0]);
            n_items++;
            void'(exp_q.pop_front());
          end
        end
      end
      if (pass_done) begin
        pd_cnt++;
        chk("pass_done_width", prev_pd, 0);
      end
      prev_pd = pass_done;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      prev_pd = 1'b0;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass_done"}, pass_done, 0);
    chk({tag, "_rd_en"}, feat_rd_en, 0);
    chk({tag, "_addr"}, feat_addr, 0);
    chk({tag, "_seg"}, mapping_hv_segment, 0);
    chk({tag, "_valid"}, item_valid, 0);
    chk({tag, "_feat"}, item_feat, 0);
    chk({tag, "_level"}, item_level, 0);
  endtask

  task automatic begin_sample(input bit poke);
    build_model();
    pd_cnt   = 0;
    done_cnt = 0;
    n_items  = 0;
    done_cyc = -1;
    obs_q.delete();
    item_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_rd_en", feat_rd_en, 1);
    chk("first_addr", feat_addr, 0);
    chk("first_busy", busy, 1);
    if (poke) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic finish_sample(input int exp_off, input bit rnd);
    for (int i = 0; i < 600 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (rnd) item_ready = ($urandom_range(0, 2) != 0);
    end
    item_ready = 1'b1;
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, required one within 600 cycles");
    end
    repeat (2) @(posedge clk);
    #1;
    chk("done_count", done_cnt, 1);
    chk("pass_done_count", pd_cnt, 2);
    chk("item_count", n_items, n_exp);
    chk("items_left", exp_q.size(), 0);
    chk("idle_after_done", busy, 0);
    if (exp_off >= 0) chk("done_cycle", done_cyc - t0, exp_off);
  endtask

  task automatic load(input logic [31:0] d, input logic [3:0] k);
    for (int f = 0; f < NF; f++) begin
      mem[f]   = d[8*f +: 8];
      kmask[f] = k[f];
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    item_ready = 1'b0;
    load(32'hFF80_1F00, 4'b1111);
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;

    // all kept, stray start while busy
    begin_sample(1'b1);
    finish_sample(26, 1'b0);
    if (obs_q.size() == 8) begin
      chk("lvl_f1", obs_q[1].lvl, 1);
      chk("lvl_f2", obs_q[2].lvl, 8);
      chk("lvl_f3", obs_q[3].lvl, 15);
      chk("seg_item4", obs_q[4].seg, 1);
    end else begin
      chk("obs_size", obs_q.size(), 8);
    end

    // pruning mask {1,0,1,0}
    load(32'hFF80_1F00, 4'b0101);
`ifdef QTZ_PRUNE_EN
    begin_sample(1'b0);
    finish_sample(22, 1'b0);
    chk("prune_items", n_items, 4);
`else
    begin_sample(1'b0);
    finish_sample(26, 1'b0);
    chk("prune_items", n_items, 8);
`endif

    // backpressure on item 2
    load(32'hFF80_1F00, 4'b1111);
    begin_sample(1'b0);
    for (int i = 0; i < 50; i++) begin
      if (item_valid && item_feat == 2) break;
      @(posedge clk); #1;
    end
    item_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", item_valid, 1);
      chk("bp_feat", item_feat, 2);
      chk("bp_level", item_level, 8);
      chk("bp_no_rd", feat_rd_en, 0);
    end
    @(posedge clk);
    #1 item_ready = 1'b1;
    finish_sample(31, 1'b0);

    // reset during an EMIT of segment 1
    begin_sample(1'b0);
    for (int i = 0; i < 100; i++) begin
      if (item_valid && mapping_hv_segment == 1) break;
      @(posedge clk); #1;
    end
    chk("pre_reset_valid", item_valid, 1);
    rst_n = 1'b0;
    #1 check_zero("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    begin_sample(1'b0);
    finish_sample(26, 1'b0);
    if (obs_q.size() > 0) begin
      chk("restart_feat", obs_q[0].feat, 0);
      chk("restart_seg", obs_q[0].seg, 0);
    end

    // everything pruned
    load(32'h1234_5678, 4'b0000);
    begin_sample(1'b0);
`ifdef QTZ_PRUNE_EN
    finish_sample(18, 1'b0);
    chk("all_pruned_items", n_items, 0);
`else
    finish_sample(26, 1'b0);
    chk("all_pruned_items", n_items, 8);
`endif

    // randomized samples
    for (int r = 0; r < 6; r++) begin
      load($urandom, 4'($urandom_range(0, 15)));
      begin_sample(r == 2);
      finish_sample((r == 0) ? ideal_off() : -1, r != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
